// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core.
// Sequences Fetch/Decode/Execute/Memory/Writeback and drives datapath controls.
module multicycle_main_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Held as a plain 4-bit vector so codes 11-15 are representable
  // and recover cleanly to Fetch.
  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl_q;

  logic is_lw;
  logic is_sw;
  logic is_r;
  logic is_i;
  logic is_beq;
  logic is_jal;

  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_r   = (op == OP_R);
  assign is_i   = (op == OP_I);
  assign is_beq = (op == OP_BEQ);
  assign is_jal = (op == OP_JAL);

  // Control word for a given state; anything unlisted stays zero.
  function automatic ctrl_t ctrl_of(input logic [3:0] s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.adr_src    = 1'b0;
        c.alu_src_a  = 2'b00;
        c.alu_src_b  = 2'b10;
        c.alu_op     = 2'b00;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b00;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b00;
      end
      S_MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = 2'b00;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.result_src = 2'b00;
        c.mem_write  = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.result_src = 2'b00;
        c.reg_write  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = 2'b10;
        c.alu_src_b  = 2'b00;
        c.alu_op     = 2'b01;
        c.result_src = 2'b00;
        c.branch     = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.alu_op     = 2'b00;
        c.result_src = 2'b00;
        c.pc_update  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; op is only looked at in Decode and MemAdr.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_d = S_MEMADR;
          is_r:         state_d = S_EXECR;
          is_i:         state_d = S_EXECI;
          is_beq:       state_d = S_BEQ;
          is_jal:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        unique case (1'b1)
          is_lw:   state_d = S_MEMREAD;
          is_sw:   state_d = S_MEMWRITE;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State and control word registered together so outputs are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_of(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
    end
  end

  // Reset forces every output low immediately, killing any in-flight strobe.
  ctrl_t ctrl_o;
  assign ctrl_o    = rst ? '0 : ctrl_q;
  assign state     = rst ? 4'd0 : state_q;
  assign PCUpdate  = ctrl_o.pc_update;
  assign Branch    = ctrl_o.branch;
  assign RegWrite  = ctrl_o.reg_write;
  assign MemWrite  = ctrl_o.mem_write;
  assign IRWrite   = ctrl_o.ir_write;
  assign AdrSrc    = ctrl_o.adr_src;
  assign ResultSrc = ctrl_o.result_src;
  assign ALUSrcA   = ctrl_o.alu_src_a;
  assign ALUSrcB   = ctrl_o.alu_src_b;
  assign ALUOp     = ctrl_o.alu_op;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm.
// Cycle vectors and scoreboard checks of state and all control outputs.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       PCUpdate;
  logic       Branch;
  logic       RegWrite;
  logic       MemWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [3:0] state;

  multicycle_main_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .PCUpdate  (PCUpdate),
    .Branch    (Branch),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .state     (state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] UNS = 7'b1110011;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [3:0] st;
  } vec_t;

  vec_t        vecs[$];
  logic [17:0] sb[$];
  int          n_run  = 0;
  int          n_fail = 0;

  // Expected control word per state:
  // {PCU,Br,RW,MW,IRW,Adr,RS[1:0],A[1:0],B[1:0],Op[1:0]}
  function automatic logic [13:0] spec_ctrl(input logic [3:0] s);
    case (s)
      4'd0:    return 14'b1_0_0_0_1_0_10_00_10_00;
      4'd1:    return 14'b0_0_0_0_0_0_00_01_01_00;
      4'd2:    return 14'b0_0_0_0_0_0_00_10_01_00;
      4'd3:    return 14'b0_0_0_0_0_1_00_00_00_00;
      4'd4:    return 14'b0_0_1_0_0_0_01_00_00_00;
      4'd5:    return 14'b0_0_0_1_0_1_00_00_00_00;
      4'd6:    return 14'b0_0_0_0_0_0_00_10_00_10;
      4'd7:    return 14'b0_0_0_0_0_0_00_10_01_10;
      4'd8:    return 14'b0_0_1_0_0_0_00_00_00_00;
      4'd9:    return 14'b0_1_0_0_0_0_00_10_00_01;
      4'd10:   return 14'b1_0_0_0_0_0_00_01_10_00;
      default: return 14'b0;
    endcase
  endfunction

  function automatic logic [17:0] expect_of(input logic r,
                                            input logic [3:0] s);
    if (r) return 18'b0;
    return {s, spec_ctrl(s)};
  endfunction

  function automatic void add(input logic r, input logic [6:0] o,
                              input logic [3:0] s);
    vec_t v;
    v.rst = r;
    v.op  = o;
    v.st  = s;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name);
    logic [17:0] act;
    logic [17:0] exp;
    act = {state, PCUpdate, Branch, RegWrite, MemWrite, IRWrite,
           AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
    n_run++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %b", name, act);
      return;
    end
    exp = sb.pop_front();
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
               name, act[17:14], act[13:0], exp[17:14], exp[13:0]);
    end
  endtask

  // Drive one cycle at the negedge, then compare the current-state outputs.
  task automatic cycle(input logic r, input logic [6:0] o,
                       input logic [3:0] s, input string name);
    rst = r;
    op  = o;
    sb.push_back(expect_of(r, s));
    #1;
    check(name);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    op  = 7'd0;

    // reset
    add(1, LW, 0); add(1, LW, 0);
    // lw
    add(0, LW, 0); add(0, LW, 1); add(0, LW, 2);
    add(0, LW, 3); add(0, LW, 4);
    // sw then R back-to-back
    add(0, SW, 0); add(0, SW, 1); add(0, SW, 2); add(0, SW, 5);
    add(0, RT, 0); add(0, RT, 1); add(0, RT, 6); add(0, RT, 8);
    // beq then jal
    add(0, BQ, 0); add(0, BQ, 1); add(0, BQ, 9);
    add(0, JL, 0); add(0, JL, 1); add(0, JL, 10); add(0, JL, 8);
    // unsupported opcode is a 2-cycle NOP
    add(0, UNS, 0); add(0, UNS, 1);
    // I-type, op switches to sw while in ExecuteI
    add(0, IT, 0); add(0, IT, 1); add(0, SW, 7); add(0, SW, 8);
    // sw decoded, op changes to R in MemAdr -> back to Fetch
    add(0, SW, 0); add(0, SW, 1); add(0, RT, 2);
    // lw interrupted by reset in MemRead, held 2 cycles
    add(0, LW, 0); add(0, LW, 1); add(0, LW, 2); add(0, LW, 3);
    add(1, LW, 3); add(1, LW, 0);
    add(0, LW, 0); add(0, LW, 1);

    @(negedge clk);
    foreach (vecs[i])
      cycle(vecs[i].rst, vecs[i].op, vecs[i].st,
            $sformatf("vec%0d", i));

    // Illegal state code: bring the FSM to Fetch, walk into BEQ,
    // then override the state register with 13.
    cycle(1, UNS, 0, "ill_rst");
    cycle(0, BQ, 0, "ill_fetch");
    cycle(0, BQ, 1, "ill_decode");
    force dut.state_q = 4'd13;
    op = BQ;
    sb.push_back(expect_of(0, 4'd13) & 18'h3C000);
    #1;
    begin
      logic [17:0] e;
      n_run++;
      e = sb.pop_front();
      if (state !== e[17:14]) begin
        n_fail++;
        $display("FAIL ill_forced: got state=%0d, want state=%0d",
                 state, e[17:14]);
      end
    end
    release dut.state_q;
    @(negedge clk);
    cycle(0, BQ, 0, "ill_recover");
    cycle(0, BQ, 1, "ill_next");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule
